// File: rtl/pmp_scan_checker.sv
// Multi-cycle PMP checker: evaluates ENTRIES_PER_CYCLE entries per cycle and answers
// one request at a time through a valid/ready response handshake.
// Optional fault log of denied accesses is enabled by defining PMP_SCAN_CHECKER_FAULT_LOG_EN.
module pmp_scan_checker #(
  parameter int unsigned PLEN              = 34,
  parameter int unsigned PMP_LEN           = 32,
  parameter int unsigned NR_ENTRIES        = 16,
  parameter int unsigned ENTRIES_PER_CYCLE = 4,
  localparam int unsigned NrE  = (NR_ENTRIES > 0) ? NR_ENTRIES : 1,
  localparam int unsigned IdxW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [PLEN-1:0]        addr_i,
  input  logic [2:0]             access_type_i,
  input  logic [1:0]             priv_lvl_i,
  input  logic [NrE*PMP_LEN-1:0] conf_addr_i,
  input  logic [NrE*8-1:0]       conf_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   allow_o,
  output logic                   match_valid_o,
  output logic [IdxW-1:0]        match_idx_o,
`ifdef PMP_SCAN_CHECKER_FAULT_LOG_EN
  input  logic                   fault_clr_i,
  output logic                   fault_valid_o,
  output logic [PLEN-1:0]        fault_addr_o,
  output logic [15:0]            fault_cnt_o,
`endif
  input  logic                   flush_i
);

  localparam int unsigned Epc      = (ENTRIES_PER_CYCLE > 0) ? ENTRIES_PER_CYCLE : 1;
  localparam int unsigned NrGroups = (NR_ENTRIES > 0) ? NR_ENTRIES / Epc : 1;
  localparam int unsigned GrpW     = (NrGroups > 1) ? $clog2(NrGroups) : 1;
  localparam logic [GrpW-1:0] LastGrp = GrpW'(NrGroups - 1);
  localparam logic [1:0] PrivM = 2'b11;

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e            state_q, state_d;
  logic [GrpW-1:0]   grp_q, grp_d;
  logic [PLEN-1:0]   addr_q;
  logic [2:0]        type_q;
  logic [1:0]        priv_q;
  logic              allow_q, allow_d;
  logic              mvalid_q, mvalid_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [NrE-1:0]    applicable;
  logic              hit;
  logic [IdxW-1:0]   hit_idx;
  logic [2:0]        hit_xwr;
  logic              accept;

  assign accept = (state_q == StIdle) && req_valid_i;

  // Match and privilege filter for every entry against the registered request address.
  always_comb begin
    logic [PMP_LEN-1:0] word_addr;
    logic [PMP_LEN-1:0] cur;
    logic [PMP_LEN-1:0] prev;
    logic [PMP_LEN-1:0] mask;
    logic [7:0]         cfg;
    logic               m;
    word_addr  = PMP_LEN'(addr_q[PLEN-1:2]);
    prev       = '0;
    cur        = '0;
    mask       = '0;
    cfg        = '0;
    m          = 1'b0;
    applicable = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      cur = conf_addr_i[i*PMP_LEN +: PMP_LEN];
      cfg = conf_i[i*8 +: 8];
      case (cfg[4:3])
        2'b01:   m = (prev <= word_addr) && (word_addr < cur);
        2'b10:   m = (word_addr == cur);
        2'b11: begin
          // Trailing ones plus the first zero above them form the don't-care field.
          mask = ~(cur ^ (cur + PMP_LEN'(1)));
          m    = ((word_addr & mask) == (cur & mask));
        end
        default: m = 1'b0;
      endcase
      applicable[i] = m && ((priv_q != PrivM) || cfg[7]);
      prev = cur;
    end
  end

  // Lowest applicable entry within the group currently being scanned.
  always_comb begin
    int unsigned e;
    hit     = 1'b0;
    hit_idx = '0;
    hit_xwr = '0;
    e       = 0;
    for (int unsigned j = 0; j < Epc; j++) begin
      e = 32'(grp_q) * Epc + j;
      if (!hit && (e < NR_ENTRIES) && applicable[e]) begin
        hit     = 1'b1;
        hit_idx = IdxW'(e);
        hit_xwr = conf_i[e*8 +: 3];
      end
    end
  end

  // Next-state and response computation.
  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    allow_d  = allow_q;
    mvalid_d = mvalid_q;
    idx_d    = idx_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          grp_d = '0;
          if (NR_ENTRIES == 0) begin
            state_d  = StResp;
            allow_d  = 1'b1;
            mvalid_d = 1'b0;
            idx_d    = '0;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (hit) begin
          state_d  = StResp;
          allow_d  = ((type_q & hit_xwr) == type_q);
          mvalid_d = 1'b1;
          idx_d    = hit_idx;
        end else if (grp_q == LastGrp) begin
          state_d  = StResp;
          allow_d  = (priv_q == PrivM);
          mvalid_d = 1'b0;
          idx_d    = '0;
        end else begin
          grp_d = grp_q + GrpW'(1);
        end
      end
      StResp: begin
        if (flush_i || rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, group counter, captured request and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      grp_q    <= '0;
      addr_q   <= '0;
      type_q   <= '0;
      priv_q   <= '0;
      allow_q  <= 1'b0;
      mvalid_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      allow_q  <= allow_d;
      mvalid_q <= mvalid_d;
      idx_q    <= idx_d;
      if (accept) begin
        addr_q <= addr_i;
        type_q <= access_type_i;
        priv_q <= priv_lvl_i;
      end
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign rsp_valid_o   = (state_q == StResp);
  assign allow_o       = allow_q;
  assign match_valid_o = mvalid_q;
  assign match_idx_o   = idx_q;

`ifdef PMP_SCAN_CHECKER_FAULT_LOG_EN
  logic            fvalid_q;
  logic [PLEN-1:0] faddr_q;
  logic [15:0]     fcnt_q;
  logic            denied_hs;

  assign denied_hs = (state_q == StResp) && rsp_ready_i && !flush_i && !allow_q;

  // Fault log: first denied address is sticky, count saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fvalid_q <= 1'b0;
      faddr_q  <= '0;
      fcnt_q   <= '0;
    end else if (fault_clr_i) begin
      fvalid_q <= denied_hs;
      faddr_q  <= denied_hs ? addr_q : '0;
      fcnt_q   <= denied_hs ? 16'd1 : 16'd0;
    end else if (denied_hs) begin
      if (fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 16'd1;
      if (!fvalid_q) begin
        fvalid_q <= 1'b1;
        faddr_q  <= addr_q;
      end
    end
  end

  assign fault_valid_o = fvalid_q;
  assign fault_addr_o  = faddr_q;
  assign fault_cnt_o   = fcnt_q;
`endif

endmodule

// File: doc/pmp_scan_checker.md
PMP_SCAN_CHECKER -- requirements
Module: pmp_scan_checker

Interface
REQ-001 SHALL have parameter PLEN, default 34, physical address width.
REQ-002 SHALL have parameter PMP_LEN, default 32, pmpaddr register width (address bits [PLEN-1:2]).
REQ-003 SHALL have parameter NR_ENTRIES, default 16, PMP entry count (0..64 legal).
REQ-004 SHALL have parameter ENTRIES_PER_CYCLE, default 4, entries evaluated per scan cycle; must divide NR_ENTRIES when NR_ENTRIES>0.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: req_valid_i in 1; req_ready_o out 1; addr_i in PLEN; access_type_i in 3 {X,W,R}; priv_lvl_i in 2 (M=2'b11).
REQ-007 SHALL have ports: conf_addr_i in NR_ENTRIES*PMP_LEN; conf_i in NR_ENTRIES*8 (per entry: [7] L, [4:3] A, [2:0] XWR).
REQ-008 SHALL have ports: rsp_valid_o out 1; rsp_ready_i in 1; allow_o out 1; match_valid_o out 1; match_idx_o out max(1,$clog2(NR_ENTRIES)); flush_i in 1.

Function
REQ-009 FSM states: IDLE, SCAN, RESP; req_ready_o=1 only in IDLE; one request in flight.
REQ-010 On req_valid_i&req_ready_o: register addr_i, access_type_i, priv_lvl_i; clear group counter; go SCAN (IDLE->RESP directly when NR_ENTRIES=0, allow_o=1, match_valid_o=0).
REQ-011 conf_i/conf_addr_i are read live during SCAN and SHALL be held stable by the CSR file from acceptance to response handshake.
REQ-012 Per SCAN cycle: evaluate entries g*EPC..g*EPC+EPC-1; group counter g wraps never, increments by 1 per cycle.
REQ-013 Match: A=OFF never; TOR prev<=a<cur with prev=0 for entry 0; NA4 a==cur; NAPOT with k trailing ones in cur, compare bits above k+1 of a and cur; a=addr[PLEN-1:2] zero-extended/truncated to PMP_LEN.
REQ-014 Entry applicable when matched and (priv!=M or L=1); lowest applicable index wins.
REQ-015 First group with an applicable entry: go RESP, allow_o=((type&XWR)==type), match_valid_o=1, match_idx_o=index.
REQ-016 Last group with none: go RESP, allow_o=(priv==M), match_valid_o=0, match_idx_o=0.
REQ-017 Latency: rsp_valid_o rises g+1 cycles after acceptance edge (g = hit group); worst case NR_ENTRIES/EPC cycles.
REQ-018 RESP: rsp_valid_o and result held stable until rsp_ready_i; on handshake go IDLE (no same-cycle re-accept).
REQ-019 flush_i in SCAN or RESP: next state IDLE, rsp_valid_o=0, no response; flush_i overrides rsp_ready_i; no effect in IDLE.

Reset
REQ-020 rst_ni low asynchronously: state IDLE, rsp_valid_o=0, allow_o=0, match_valid_o=0, match_idx_o=0, group counter 0, log state cleared.
REQ-021 Reset mid-SCAN/RESP SHALL drop the request with no response after reset release.

Configuration
REQ-022 Macro PMP_SCAN_CHECKER_FAULT_LOG_EN defined: add ports fault_clr_i in 1, fault_valid_o out 1, fault_addr_o out PLEN, fault_cnt_o out 16.
REQ-023 With macro: on response handshake with allow_o=0, fault_cnt_o increments saturating at 16'hFFFF; if fault_valid_o=0, capture addr into fault_addr_o and set fault_valid_o.
REQ-024 With macro: fault_clr_i clears all log state; simultaneous denied handshake -> fault_valid_o=1, fault_addr_o=new addr, fault_cnt_o=1.
REQ-025 Without macro: ports and logic absent; response behaviour identical.

Verification
REQ-026 NR=16,EPC=4; entry 5 NAPOT conf_addr=0x0000_01FF, XWR=001, priv U, read addr 0x400 -> rsp_valid 2 cycles after accept, allow=1, match_idx=5.
REQ-027 Same setup, write access -> allow=0, match_valid=1, idx=5; with macro fault_cnt=1, fault_addr=0x400.
REQ-028 Entry 14 TOR [0x100,0x200) L=0, priv M, addr 0x500 -> 4-cycle latency, match_valid=0, allow=1; set L=1, XWR=000, addr 0x500 -> allow=0, idx=14.
REQ-029 No match, priv S, all A=OFF -> allow=0 after 4 cycles; rsp_ready_i low 3 cycles -> outputs stable, req_ready_o=0 throughout.
REQ-030 flush_i in 2nd SCAN cycle -> no rsp_valid, req_ready_o=1 next cycle; rst_ni low in RESP -> rsp_valid_o=0 immediately.
